mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer for the filter's multiply-accumulate datapath.
- On each sample strobe it pulses the sample-delay-line shift and clears the 25-bit accumulator through the accumulator input mux (select = 2'b10).
- It then steps the tap address across all coefficients with the mux held on accumulator feedback (select = 2'b01), and pulses done when the result is final.
- Bypass mode loads the raw input term (select = 2'b00) instead of running the taps.

Parameters:
NTAPS, 8, number of filter taps issued per sample (2..256)
AW, 3, tap address width; must satisfy 2^AW >= NTAPS
MUL_LAT, 2, pipeline latency in cycles from tap_addr to product valid at the adder (0..7)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  sample strobe, one cycle wide; sampled only in IDLE
bypass  in  1  sampled with start; 1 = pass-through sequence
sel  out  2  accumulator mux select: 00 input term, 01 feedback, 10 zero; 11 never driven
acc_en  out  1  accumulator register load enable
shift_en  out  1  sample delay-line shift enable
tap_addr  out  AW  coefficient/sample tap index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: accumulator holds the final value
overrun  out  1  one-cycle pulse: start arrived while busy and was dropped

Behaviour:
- Reset (async, immediate): state = IDLE, sel = 01, acc_en = 0, shift_en = 0, tap_addr = 0, busy = 0, done = 0, overrun = 0, delay pipe cleared.
- Reset mid-sequence aborts immediately. The next start after reset release begins a fresh sequence.
- States: IDLE, SHIFT, CLR, MAC, DRAIN, LOAD, DONE. All outputs are decoded from registered state, tap counter and delay pipe only. No combinational path from inputs to outputs, except overrun, which is registered.
- IDLE: sel = 01, acc_en = 0. A start high at a clock edge latches bypass and moves to SHIFT.
- SHIFT (1 cycle): shift_en = 1. Next state is LOAD if the latched bypass = 1, else CLR.
- CLR (1 cycle): sel = 10, acc_en = 1, tap counter reset to 0. Next state MAC.
- MAC (NTAPS cycles):
  - sel = 01, tap_addr = 0,1,..,NTAPS-1 in consecutive cycles; issue flag = 1.
  - Exit to DRAIN after the cycle with tap_addr = NTAPS-1.
- acc_en for taps = issue flag delayed by MUL_LAT cycles through a shift pipe. MUL_LAT = 0 means acc_en is asserted in the MAC cycles themselves.
- acc_en output = (state == CLR) | (state == LOAD) | delayed issue.
- DRAIN (MUL_LAT cycles, skipped when MUL_LAT = 0): sel = 01, tap_addr holds NTAPS-1. Next state DONE.
- LOAD (1 cycle, bypass only): sel = 00, acc_en = 1. Next state DONE.
- DONE (1 cycle): done = 1, sel = 01, acc_en = 0. Next state IDLE.
- tap_addr returns to 0 in IDLE.
- Latency from the start cycle to the done cycle:
  - normal: NTAPS + MUL_LAT + 3 cycles;
  - bypass: 3 cycles.
- Back-to-back: a start coincident with DONE is an overrun; start is accepted only in IDLE, so the minimum sample period is latency + 1.
- start while busy: overrun pulses in the following cycle; sequence unaffected, no queuing.
- bypass changes outside the start cycle are ignored.
- Tap counter width is AW. The counter never wraps, because exit is at NTAPS-1.

Test Plan:
- Reset then idle: assert reset mid-cycle, no clock -> all outputs at reset values immediately; sel = 01 held in IDLE for 20 cycles with no start.
- Normal sequence, NTAPS = 8, MUL_LAT = 2, start at cycle 0 -> required response:
  - shift_en at cycle 1;
  - sel = 10 with acc_en at cycle 2;
  - tap_addr 0..7 at cycles 3..10;
  - acc_en at cycles 5..12;
  - done at cycle 13;
  - busy at cycles 1..13;
  - exactly 9 acc_en pulses.
- Bypass: start with bypass = 1 at cycle 0 -> shift_en at cycle 1; sel = 00 with acc_en at cycle 2; done at cycle 3; tap_addr stays 0; sel never 10.
- Overrun: start at cycle 0, again at cycle 6 and at cycle 13 (the DONE cycle) -> overrun pulses at cycles 7 and 14; done only at cycle 13; a start at cycle 14 is accepted.
- Reset mid-MAC: reset asserted at cycle 6 for 2 cycles -> outputs return to reset values asynchronously, no done; a start after release gives a full 13-cycle sequence.
- Parameter corners:
  - MUL_LAT = 0, NTAPS = 2 -> acc_en in CLR and both MAC cycles, no DRAIN, done at cycle 5;
  - NTAPS = 256, AW = 8 -> tap_addr reaches 255 and never wraps.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the filter's multiply-accumulate datapath.
// One sample strobe shifts the delay line, clears the accumulator, walks the
// tap address across every coefficient, waits for the multiplier pipeline to
// drain and then flags done. Bypass replaces the tap walk with a single load
// of the raw input term.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, accumulator held on feedback
// SHIFT | pulse the sample delay-line shift
// CLR   | load zero into the accumulator, reset the tap counter
// MAC   | issue taps 0..NTAPS-1, one per cycle
// DRAIN | wait MUL_LAT cycles for the last products to land
// LOAD  | bypass: load the raw input term into the accumulator
// DONE  | accumulator holds the final value

module mac_seq_ctrl #(
  parameter int NTAPS   = 8,
  parameter int AW      = 3,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          bypass,
  output logic [1:0]    sel,
  output logic          acc_en,
  output logic          shift_en,
  output logic [AW-1:0] tap_addr,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] CLR   = 3'd2;
  localparam logic [2:0] MAC   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] LOAD  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [1:0] SEL_IN  = 2'b00;
  localparam logic [1:0] SEL_FB  = 2'b01;
  localparam logic [1:0] SEL_ZRO = 2'b10;

  localparam logic [AW-1:0] LAST_TAP   = AW'(NTAPS - 1);
  // Drain down-counter is loaded with MUL_LAT-1 so that it terminates on zero.
  localparam logic [2:0]    DRAIN_LOAD = 3'((MUL_LAT > 0) ? (MUL_LAT - 1) : 0);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] tap_cnt;
  logic [2:0]    drain_cnt;
  logic          byp_q;
  logic          issue;
  logic          issue_dly;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   state_nxt = byp_q ? LOAD : CLR;
      CLR:     state_nxt = MAC;
      MAC:     if (tap_cnt == LAST_TAP) state_nxt = (MUL_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_cnt == 3'd0) state_nxt = DONE;
      LOAD:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bypass is captured only with an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       byp_q <= 1'b0;
    else if (state == IDLE && start) byp_q <= bypass;
  end

  // Tap counter: walks during MAC, parks on the last tap through DRAIN/DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_cnt <= '0;
    end else begin
      case (state)
        MAC:         if (tap_cnt != LAST_TAP) tap_cnt <= tap_cnt + AW'(1);
        IDLE, CLR,
        DONE:        tap_cnt <= '0;
        default:     tap_cnt <= tap_cnt;
      endcase
    end
  end

  // Drain down-counter, reloaded on every MAC cycle so it is fresh on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       drain_cnt <= 3'd0;
    else if (state == MAC)                           drain_cnt <= DRAIN_LOAD;
    else if (state == DRAIN && drain_cnt != 3'd0)    drain_cnt <= drain_cnt - 3'd1;
  end

  // A start outside IDLE is dropped and reported one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= start && (state != IDLE);
  end

  assign issue = (state == MAC);

  // Align accumulator loads with product arrival at the adder
  generate
    if (MUL_LAT == 0) begin : g_nodly
      assign issue_dly = issue;
    end else begin : g_dly
      logic [MUL_LAT-1:0] pipe;
      // Issue-flag shift pipe, one stage per multiplier latency cycle
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe <= '0;
        end else begin
          pipe[0] <= issue;
          for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign issue_dly = pipe[MUL_LAT-1];
    end
  endgenerate

  // Output decode from registered state, counter and delay pipe only
  always_comb begin
    sel = SEL_FB;
    if (state == CLR)  sel = SEL_ZRO;
    if (state == LOAD) sel = SEL_IN;
    acc_en   = (state == CLR) || (state == LOAD) || issue_dly;
    shift_en = (state == SHIFT);
    busy     = (state != IDLE);
    done     = (state == DONE);
    tap_addr = tap_cnt;
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: three sequencer instances (8 taps/lat 2, 2 taps/lat 0,
// 256 taps/lat 2) driven by directed and random strobes. The reference model
// tracks each instance as idle or "k cycles after an accepted start" and
// derives every output from that offset arithmetically.

module tb_mac_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [2:0] bypass;

  logic [1:0] sel0, sel1, sel2;
  logic       acc0, acc1, acc2;
  logic       sh0, sh1, sh2;
  logic [2:0] tap0;
  logic [0:0] tap1;
  logic [7:0] tap2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       ovr0, ovr1, ovr2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cnt0 = 0;
  int done_cnt0 = 0;
  int max_tap2 = 0;

  // model state per instance
  int nt [3] = '{8, 2, 256};
  int ml [3] = '{2, 0, 2};
  bit act [3];
  int k   [3];
  bit bym [3];
  bit ovm [3];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.NTAPS(8), .AW(3), .MUL_LAT(2)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .bypass(bypass[0]),
    .sel(sel0), .acc_en(acc0), .shift_en(sh0), .tap_addr(tap0),
    .busy(busy0), .done(done0), .overrun(ovr0));

  mac_seq_ctrl #(.NTAPS(2), .AW(1), .MUL_LAT(0)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .bypass(bypass[1]),
    .sel(sel1), .acc_en(acc1), .shift_en(sh1), .tap_addr(tap1),
    .busy(busy1), .done(done1), .overrun(ovr1));

  mac_seq_ctrl #(.NTAPS(256), .AW(8), .MUL_LAT(2)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .bypass(bypass[2]),
    .sel(sel2), .acc_en(acc2), .shift_en(sh2), .tap_addr(tap2),
    .busy(busy2), .done(done2), .overrun(ovr2));

  function automatic logic [14:0] obs_vec(int d);
    case (d)
      0:       return {sel0, acc0, sh0, {5'b0, tap0}, busy0, done0, ovr0};
      1:       return {sel1, acc1, sh1, {7'b0, tap1}, busy1, done1, ovr1};
      default: return {sel2, acc2, sh2, tap2, busy2, done2, ovr2};
    endcase
  endfunction

  function automatic logic [14:0] exp_vec(int d);
    logic [1:0] s  = 2'b01;
    logic       a  = 1'b0;
    logic       sh = 1'b0;
    logic       b  = 1'b0;
    logic       dn = 1'b0;
    int         tp = 0;
    int         n  = nt[d];
    int         l  = ml[d];
    int         kk = k[d];
    if (act[d]) begin
      b = 1'b1;
      if (kk == 1) sh = 1'b1;
      if (bym[d]) begin
        if (kk == 2) begin s = 2'b00; a = 1'b1; end
        if (kk == 3) dn = 1'b1;
      end else begin
        if (kk == 2) begin s = 2'b10; a = 1'b1; end
        if (kk >= 3 && kk < 3 + n) tp = kk - 3;
        else if (kk >= 3 + n)      tp = n - 1;
        if (kk >= 3 + l && kk < 3 + n + l) a = 1'b1;
        if (kk == n + l + 3) dn = 1'b1;
      end
    end
    return {s, a, sh, 8'(tp), b, dn, ovm[d]};
  endfunction

  function automatic int latency(int d);
    return bym[d] ? 3 : nt[d] + ml[d] + 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [14:0] o;
    for (int d = 0; d < 3; d++) begin
      o = obs_vec(d);
      check($sformatf("outs_dut%0d_cyc%0d", d, cyc), {17'b0, o}, {17'b0, exp_vec(d)});
      if (d == 0 && o[12]) acc_cnt0++;
      if (d == 0 && o[1])  done_cnt0++;
      if (d == 2 && int'(o[10:3]) > max_tap2) max_tap2 = int'(o[10:3]);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      act[d] = 1'b0; k[d] = 0; bym[d] = 1'b0; ovm[d] = 1'b0;
    end
  endtask

  // one clock cycle: check, drive, advance model at the edge
  task automatic step(input bit [2:0] st, input bit [2:0] bp);
    check_all();
    start  = st;
    bypass = bp;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        act[d] = 1'b0; ovm[d] = 1'b0;
      end else begin
        ovm[d] = st[d] && act[d];
        if (act[d]) begin
          k[d]++;
          if (k[d] > latency(d)) act[d] = 1'b0;
        end else if (st[d]) begin
          act[d] = 1'b1; k[d] = 1; bym[d] = bp[d];
        end
      end
    end
    @(negedge clk);
    start = 3'b000;
    cyc++;
  endtask

  initial begin
    start  = 3'b000;
    bypass = 3'b000;
    reset  = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    step(3'b000, 3'b000);
    reset = 1'b0;

    // idle hold
    for (int i = 0; i < 20; i++) step(3'b000, 3'b000);

    // normal sequence on all instances
    cyc = 0; acc_cnt0 = 0; done_cnt0 = 0;
    step(3'b011, 3'b000);
    for (int i = 0; i < 19; i++) step(3'b000, 3'b111);
    check("acc_pulses_normal", acc_cnt0, 9);
    check("done_count_normal", done_cnt0, 1);

    // bypass sequence
    cyc = 0;
    step(3'b011, 3'b011);
    for (int i = 0; i < 8; i++) step(3'b000, 3'b000);

    // overrun: starts at 0, 6, 13 (DONE) and 14 (accepted)
    cyc = 0; done_cnt0 = 0;
    for (int c = 0; c < 30; c++)
      step({2'b00, (c == 0 || c == 6 || c == 13 || c == 14)}, 3'b000);
    check("done_count_overrun", done_cnt0, 2);

    // reset mid-MAC, asserted between clock edges
    cyc = 0; done_cnt0 = 0;
    step(3'b011, 3'b000);
    for (int i = 0; i < 5; i++) step(3'b000, 3'b000);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    reset = 1'b0;
    check("done_count_reset", done_cnt0, 0);
    cyc = 0;
    step(3'b011, 3'b000);
    for (int i = 0; i < 15; i++) step(3'b000, 3'b000);
    check("done_count_after_reset", done_cnt0, 1);

    // full 256-tap sequence
    cyc = 0; max_tap2 = 0;
    step(3'b100, 3'b000);
    for (int i = 0; i < 265; i++) step(3'b000, 3'b000);
    check("max_tap_256", max_tap2, 255);

    // random strobes and bypass
    cyc = 0;
    for (int i = 0; i < 500; i++) begin
      bit [2:0] st;
      for (int d = 0; d < 3; d++) st[d] = ($urandom_range(0, 4) == 0);
      step(st, 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
